csr_rmw_unit: RTL and testbench



---
 rtl/cpu_params_pkg.sv | 40 ++++
 rtl/csr_rmw_alu.sv | 28 ++
 rtl/csr_rmw_unit.sv | 175 +++++++++++++++++
 tb/tb_csr_rmw_unit.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_params_pkg.sv
// Shared CPU parameters and CSR read-modify-write types.
// Holds the operand width, CSR op/state enums, address field constants.
package cpu_params_pkg;

  localparam int RSZ = 32;

  typedef enum logic [1:0] {
    CSR_OP_ILL = 2'd0,
    CSR_OP_RW  = 2'd1,
    CSR_OP_RS  = 2'd2,
    CSR_OP_RC  = 2'd3
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_rmw_state_t;

  // addr[11:10]==2'b11 marks a read-only CSR
  localparam logic [1:0] ADDR_RO = 2'b11;
  localparam int RO_LSB   = 10;
  // addr[9:8] is the lowest privilege allowed to access the CSR
  localparam int PRIV_LSB = 8;

  // Set/clear forms with a zero source are pure reads.
  function automatic logic csr_wr_need(
    input csr_op_t    op,
    input logic       imm,
    input logic [4:0] uimm,
    input logic       rs1_is_x0
  );
    logic src_zero;
    src_zero = imm ? (uimm == 5'd0) : rs1_is_x0;
    return (op == CSR_OP_RW) ||
           (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !src_zero);
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational new-value computation for CSR read-modify-write.
// Ports: op, old_val, src_val, romask in; new_val out.
module csr_rmw_alu
  import cpu_params_pkg::*;
(
  input  csr_op_t          op,
  input  logic [RSZ-1:0]   old_val,
  input  logic [RSZ-1:0]   src_val,
  input  logic [RSZ-1:0]   romask,
  output logic [RSZ-1:0]   new_val
);

  logic [RSZ-1:0] raw;

  always_comb begin
    raw = old_val;
    unique case (op)
      CSR_OP_RW: raw = src_val;
      CSR_OP_RS: raw = old_val | src_val;
      CSR_OP_RC: raw = old_val & ~src_val;
      default:   raw = old_val;
    endcase
  end

  // read-only bits always keep their old value
  assign new_val = (raw & ~romask) | (old_val & romask);

endmodule

// File: rtl/csr_rmw_unit.sv
// Zicsr read-modify-write sequencer: IDLE->READ->WRITE->RESP.
// Ports: req_* from EX, csr_* to/from CSR bank, rsp_* back to pipeline.
module csr_rmw_unit
  import cpu_params_pkg::*;
(
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_imm,
  input  logic [4:0]       req_uimm,
  input  logic             req_rs1_is_x0,
  input  logic [RSZ-1:0]   req_rs1_data,
  input  logic [11:0]      req_addr,
  input  logic [1:0]       req_priv,
  output logic [11:0]      csr_rd_addr,
  input  logic [RSZ-1:0]   csr_rd_data,
  input  logic             csr_rd_illegal,
  input  logic [RSZ-1:0]   csr_romask,
  output logic             csr_wr_en,
  output logic [11:0]      csr_wr_addr,
  output logic [RSZ-1:0]   csr_wr_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RSZ-1:0]   rsp_rd_data,
  output logic             rsp_illegal
);

  csr_rmw_state_t state_q, state_d;

  csr_op_t        op_q, op_d;
  logic           imm_q, imm_d;
  logic [4:0]     uimm_q, uimm_d;
  logic           x0_q, x0_d;
  logic [RSZ-1:0] rs1_q, rs1_d;
  logic [11:0]    addr_q, addr_d;
  logic [1:0]     priv_q, priv_d;
  logic [RSZ-1:0] old_q, old_d;

  logic           wr_en_q, wr_en_d;
  logic [RSZ-1:0] wr_data_q, wr_data_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [RSZ-1:0] rsp_data_q, rsp_data_d;
  logic           rsp_ill_q, rsp_ill_d;

  logic [RSZ-1:0] src;
  logic [RSZ-1:0] alu_new;
  logic           wr_need;
  logic           illegal;

  assign src = imm_q ? {{(RSZ-5){1'b0}}, uimm_q} : rs1_q;

  csr_rmw_alu u_alu (
    .op      (op_q),
    .old_val (csr_rd_data),
    .src_val (src),
    .romask  (csr_romask),
    .new_val (alu_new)
  );

  assign wr_need = csr_wr_need(op_q, imm_q, uimm_q, x0_q);

  assign illegal = csr_rd_illegal ||
                   (op_q == CSR_OP_ILL) ||
                   (priv_q < addr_q[PRIV_LSB +: 2]) ||
                   (wr_need && (addr_q[RO_LSB +: 2] == ADDR_RO));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    imm_d       = imm_q;
    uimm_d      = uimm_q;
    x0_d        = x0_q;
    rs1_d       = rs1_q;
    addr_d      = addr_q;
    priv_d      = priv_q;
    old_d       = old_q;
    wr_en_d     = 1'b0;
    wr_data_d   = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ill_d   = rsp_ill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = csr_op_t'(req_op);
          imm_d   = req_imm;
          uimm_d  = req_uimm;
          x0_d    = req_rs1_is_x0;
          rs1_d   = req_rs1_data;
          addr_d  = req_addr;
          priv_d  = req_priv;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        old_d = csr_rd_data;
        if (flush_in) begin
          state_d = ST_IDLE;
        end else if (illegal || !wr_need) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = illegal ? '0 : csr_rd_data;
          rsp_ill_d   = illegal;
        end else begin
          state_d   = ST_WRITE;
          wr_en_d   = 1'b1;
          wr_data_d = alu_new;
        end
      end
      // the write has committed, so a flush here cannot abort it
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = old_q;
        rsp_ill_d   = 1'b0;
      end
      ST_RESP: begin
        if (flush_in || rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_ill_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      op_q        <= CSR_OP_ILL;
      imm_q       <= 1'b0;
      uimm_q      <= '0;
      x0_q        <= 1'b0;
      rs1_q       <= '0;
      addr_q      <= '0;
      priv_q      <= '0;
      old_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      uimm_q      <= uimm_d;
      x0_q        <= x0_d;
      rs1_q       <= rs1_d;
      addr_q      <= addr_d;
      priv_q      <= priv_d;
      old_q       <= old_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ill_q   <= rsp_ill_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign csr_rd_addr = addr_q;
  assign csr_wr_en   = wr_en_q;
  assign csr_wr_addr = addr_q;
  assign csr_wr_data = wr_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd_data = rsp_data_q;
  assign rsp_illegal = rsp_ill_q;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Directed self-checking bench for csr_rmw_unit.
// Scenario tasks run in sequence; each checks its own expectations.
module tb_csr_rmw_unit;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        flush_in;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_imm;
  logic [4:0]  req_uimm;
  logic        req_rs1_is_x0;
  logic [31:0] req_rs1_data;
  logic [11:0] req_addr;
  logic [1:0]  req_priv;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_rd_illegal;
  logic [31:0] csr_romask;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd_data;
  logic        rsp_illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_in = ~clk_in;

  csr_rmw_unit dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .flush_in       (flush_in),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_imm        (req_imm),
    .req_uimm       (req_uimm),
    .req_rs1_is_x0  (req_rs1_is_x0),
    .req_rs1_data   (req_rs1_data),
    .req_addr       (req_addr),
    .req_priv       (req_priv),
    .csr_rd_addr    (csr_rd_addr),
    .csr_rd_data    (csr_rd_data),
    .csr_rd_illegal (csr_rd_illegal),
    .csr_romask     (csr_romask),
    .csr_wr_en      (csr_wr_en),
    .csr_wr_addr    (csr_wr_addr),
    .csr_wr_data    (csr_wr_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rd_data    (rsp_rd_data),
    .rsp_illegal    (rsp_illegal)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Presents one request for a single cycle; DUT is in READ on return.
  task automatic issue(
    input logic [1:0]  op,
    input logic        imm,
    input logic [4:0]  uimm,
    input logic        x0,
    input logic [31:0] rs1,
    input logic [11:0] addr,
    input logic [1:0]  priv
  );
    req_op        = op;
    req_imm       = imm;
    req_uimm      = uimm;
    req_rs1_is_x0 = x0;
    req_rs1_data  = rs1;
    req_addr      = addr;
    req_priv      = priv;
    req_valid     = 1'b1;
    step();
    req_valid     = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if (csr_wr_en !== 1'b0)
      $display("FAIL rst_wr_en got %0h exp 0", csr_wr_en);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b0)
      $display("FAIL rst_rsp_valid got %0h exp 0", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if ({csr_wr_data, rsp_rd_data} !== 64'd0)
      $display("FAIL rst_data got %0h/%0h exp 0",
               csr_wr_data, rsp_rd_data);
    else pass_cnt++;
    total_cnt++;
    if ({csr_rd_addr, rsp_illegal} !== 13'd0)
      $display("FAIL rst_addr got %0h/%0h exp 0",
               csr_rd_addr, rsp_illegal);
    else pass_cnt++;
    step();
    step();
    reset_in = 1'b0;
    step();
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL rst_req_ready got %0h exp 1", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_rs();
    csr_rd_data = 32'h0000_00F0;
    csr_romask  = 32'h0;
    issue(2'd2, 1'b0, 5'd0, 1'b0, 32'h0F, 12'h340, 2'd3);
    total_cnt++;
    if (csr_rd_addr !== 12'h340)
      $display("FAIL rs_rd_addr got %0h exp 340", csr_rd_addr);
    else pass_cnt++;
    total_cnt++;
    if ({req_ready, csr_wr_en, rsp_valid} !== 3'b000)
      $display("FAIL rs_read_state got %b exp 000",
               {req_ready, csr_wr_en, rsp_valid});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({csr_wr_en, rsp_valid} !== 2'b10)
      $display("FAIL rs_wr_en got %b exp 10", {csr_wr_en, rsp_valid});
    else pass_cnt++;
    total_cnt++;
    if (csr_wr_data !== 32'h0000_00FF)
      $display("FAIL rs_wr_data got %0h exp ff", csr_wr_data);
    else pass_cnt++;
    total_cnt++;
    if (csr_wr_addr !== 12'h340)
      $display("FAIL rs_wr_addr got %0h exp 340", csr_wr_addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({csr_wr_en, rsp_valid, rsp_illegal} !== 3'b010)
      $display("FAIL rs_rsp got %b exp 010",
               {csr_wr_en, rsp_valid, rsp_illegal});
    else pass_cnt++;
    total_cnt++;
    if (rsp_rd_data !== 32'h0000_00F0)
      $display("FAIL rs_rd_data got %0h exp f0", rsp_rd_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL rs_done got %b exp 01", {rsp_valid, req_ready});
    else pass_cnt++;
  endtask

  task automatic test_alu_forms();
    csr_rd_data = 32'h0000_00FF;
    csr_romask  = 32'h0000_000F;
    issue(2'd3, 1'b0, 5'd0, 1'b0, 32'hFF, 12'h340, 2'd3);
    step();
    total_cnt++;
    if (csr_wr_data !== 32'h0000_000F)
      $display("FAIL rc_romask got %0h exp f", csr_wr_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rsp_rd_data !== 32'h0000_00FF)
      $display("FAIL rc_rd_data got %0h exp ff", rsp_rd_data);
    else pass_cnt++;
    step();
    csr_romask = 32'h0;
    issue(2'd3, 1'b1, 5'h05, 1'b0, 32'hFFFF_FFFF, 12'h340, 2'd3);
    step();
    total_cnt++;
    if (csr_wr_data !== 32'h0000_00FA)
      $display("FAIL rci_wr_data got %0h exp fa", csr_wr_data);
    else pass_cnt++;
    step();
    step();
    csr_rd_data = 32'hDEAD_BEEF;
    csr_romask  = 32'hFFFF_0000;
    issue(2'd1, 1'b1, 5'h1F, 1'b0, 32'h1234_5678, 12'h340, 2'd3);
    step();
    total_cnt++;
    if (csr_wr_data !== 32'hDEAD_001F)
      $display("FAIL rwi_wr_data got %0h exp dead001f", csr_wr_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rsp_rd_data !== 32'hDEAD_BEEF)
      $display("FAIL rwi_rd_data got %0h exp deadbeef", rsp_rd_data);
    else pass_cnt++;
    step();
  endtask

  task automatic test_readonly();
    csr_rd_data = 32'h0000_1234;
    csr_romask  = 32'h0;
    issue(2'd2, 1'b0, 5'd0, 1'b1, 32'hFFFF, 12'hC00, 2'd3);
    step();
    total_cnt++;
    if ({csr_wr_en, rsp_valid, rsp_illegal} !== 3'b010)
      $display("FAIL ro_rs_x0 got %b exp 010",
               {csr_wr_en, rsp_valid, rsp_illegal});
    else pass_cnt++;
    total_cnt++;
    if (rsp_rd_data !== 32'h0000_1234)
      $display("FAIL ro_rs_data got %0h exp 1234", rsp_rd_data);
    else pass_cnt++;
    step();
    issue(2'd2, 1'b1, 5'd0, 1'b0, 32'hFFFF, 12'hC00, 2'd3);
    step();
    total_cnt++;
    if ({csr_wr_en, rsp_valid, rsp_illegal} !== 3'b010)
      $display("FAIL ro_rsi_0 got %b exp 010",
               {csr_wr_en, rsp_valid, rsp_illegal});
    else pass_cnt++;
    step();
    issue(2'd1, 1'b0, 5'd0, 1'b0, 32'h1, 12'hC00, 2'd3);
    step();
    total_cnt++;
    if ({csr_wr_en, rsp_valid, rsp_illegal} !== 3'b011)
      $display("FAIL ro_rw got %b exp 011",
               {csr_wr_en, rsp_valid, rsp_illegal});
    else pass_cnt++;
    total_cnt++;
    if (rsp_rd_data !== 32'h0)
      $display("FAIL ro_rw_data got %0h exp 0", rsp_rd_data);
    else pass_cnt++;
    step();
  endtask

  task automatic test_illegal();
    csr_rd_data = 32'h0000_1800;
    issue(2'd1, 1'b0, 5'd0, 1'b0, 32'h8, 12'h300, 2'd0);
    step();
    total_cnt++;
    if ({csr_wr_en, rsp_valid, rsp_illegal} !== 3'b011)
      $display("FAIL priv_u got %b exp 011",
               {csr_wr_en, rsp_valid, rsp_illegal});
    else pass_cnt++;
    total_cnt++;
    if (rsp_rd_data !== 32'h0)
      $display("FAIL priv_u_data got %0h exp 0", rsp_rd_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (csr_wr_en !== 1'b0)
      $display("FAIL priv_u_nowr got %0h exp 0", csr_wr_en);
    else pass_cnt++;
    issue(2'd0, 1'b0, 5'd0, 1'b0, 32'h8, 12'h340, 2'd3);
    step();
    total_cnt++;
    if ({csr_wr_en, rsp_valid, rsp_illegal} !== 3'b011)
      $display("FAIL op0 got %b exp 011",
               {csr_wr_en, rsp_valid, rsp_illegal});
    else pass_cnt++;
    step();
    csr_rd_illegal = 1'b1;
    issue(2'd2, 1'b0, 5'd0, 1'b1, 32'h0, 12'h7FF, 2'd3);
    step();
    csr_rd_illegal = 1'b0;
    total_cnt++;
    if ({csr_wr_en, rsp_valid, rsp_illegal} !== 3'b011)
      $display("FAIL unimpl got %b exp 011",
               {csr_wr_en, rsp_valid, rsp_illegal});
    else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    csr_rd_data = 32'h0000_1111;
    rsp_ready   = 1'b0;
    issue(2'd1, 1'b0, 5'd0, 1'b0, 32'hA5A5, 12'h340, 2'd3);
    step();
    total_cnt++;
    if (csr_wr_data !== 32'h0000_A5A5)
      $display("FAIL bp_wr_data got %0h exp a5a5", csr_wr_data);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if ({rsp_valid, req_ready, csr_wr_en} !== 3'b100)
        $display("FAIL bp_hold%0d got %b exp 100", i,
                 {rsp_valid, req_ready, csr_wr_en});
      else pass_cnt++;
      total_cnt++;
      if (rsp_rd_data !== 32'h0000_1111)
        $display("FAIL bp_data%0d got %0h exp 1111", i, rsp_rd_data);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    step();
    total_cnt++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL bp_release got %b exp 01", {rsp_valid, req_ready});
    else pass_cnt++;
  endtask

  task automatic test_flush();
    csr_rd_data = 32'h0;
    issue(2'd1, 1'b0, 5'd0, 1'b0, 32'h77, 12'h340, 2'd3);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    total_cnt++;
    if ({csr_wr_en, rsp_valid, req_ready} !== 3'b001)
      $display("FAIL flush_rd got %b exp 001",
               {csr_wr_en, rsp_valid, req_ready});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({csr_wr_en, rsp_valid} !== 2'b00)
      $display("FAIL flush_rd2 got %b exp 00", {csr_wr_en, rsp_valid});
    else pass_cnt++;
    issue(2'd1, 1'b0, 5'd0, 1'b0, 32'h77, 12'h340, 2'd3);
    step();
    flush_in = 1'b1;
    total_cnt++;
    if (csr_wr_en !== 1'b1)
      $display("FAIL flush_wr_en got %0h exp 1", csr_wr_en);
    else pass_cnt++;
    step();
    flush_in = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b1)
      $display("FAIL flush_wr_rsp got %0h exp 1", rsp_valid);
    else pass_cnt++;
    rsp_ready = 1'b0;
    step();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    rsp_ready = 1'b1;
    total_cnt++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL flush_resp got %b exp 01", {rsp_valid, req_ready});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    csr_rd_data = 32'h0;
    issue(2'd1, 1'b0, 5'd0, 1'b0, 32'h55, 12'h340, 2'd3);
    step();
    total_cnt++;
    if (csr_wr_en !== 1'b1)
      $display("FAIL ar_pre got %0h exp 1", csr_wr_en);
    else pass_cnt++;
    #2;
    reset_in = 1'b1;
    #1;
    total_cnt++;
    if ({csr_wr_en, rsp_valid, req_ready} !== 3'b001)
      $display("FAIL ar_drop got %b exp 001",
               {csr_wr_en, rsp_valid, req_ready});
    else pass_cnt++;
    total_cnt++;
    if ({csr_wr_data, csr_rd_addr} !== 44'd0)
      $display("FAIL ar_zero got %0h/%0h exp 0",
               csr_wr_data, csr_rd_addr);
    else pass_cnt++;
    #1;
    reset_in = 1'b0;
    step();
    total_cnt++;
    if ({csr_wr_en, rsp_valid} !== 2'b00)
      $display("FAIL ar_after got %b exp 00", {csr_wr_en, rsp_valid});
    else pass_cnt++;
    csr_rd_data = 32'h0000_00F0;
    issue(2'd2, 1'b0, 5'd0, 1'b0, 32'h0F, 12'h340, 2'd3);
    step();
    total_cnt++;
    if ({csr_wr_en, csr_wr_data} !== {1'b1, 32'h0000_00FF})
      $display("FAIL ar_next got %b/%0h exp 1/ff",
               csr_wr_en, csr_wr_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rsp_rd_data !== 32'h0000_00F0)
      $display("FAIL ar_next_rd got %0h exp f0", rsp_rd_data);
    else pass_cnt++;
    step();
  endtask

  initial begin
    reset_in       = 1'b1;
    flush_in       = 1'b0;
    req_valid      = 1'b0;
    req_op         = 2'd0;
    req_imm        = 1'b0;
    req_uimm       = 5'd0;
    req_rs1_is_x0  = 1'b0;
    req_rs1_data   = 32'h0;
    req_addr       = 12'h0;
    req_priv       = 2'd0;
    csr_rd_data    = 32'h0;
    csr_rd_illegal = 1'b0;
    csr_romask     = 32'h0;
    rsp_ready      = 1'b1;
    test_reset();
    test_rs();
    test_alu_forms();
    test_readonly();
    test_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
